// File: rtl/tdm_demux8_pkg.sv
// Shared constants and state encoding for the 8-lane TDM demultiplexer.
package tdm_demux8_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned SLOT_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_out_buf.sv
// Valid/ready holding register for completed frames; drops a new frame when occupied.
module tdm_out_buf #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overflow
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             free;

    always_comb begin
        free       = !valid_q || out_ready;
        data_d     = data_q;
        valid_d    = valid_q && !out_ready;
        overflow_d = 1'b0;
        if (load) begin
            if (free) begin
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overflow  = overflow_q;

endmodule

// File: rtl/tdm_demux8.sv
// Time-division demultiplexer: writes slot k of the sample stream to lane k and emits whole frames.
module tdm_demux8
    import tdm_demux8_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W-1:0]        in_data,
    input  logic                in_valid,
    input  logic                in_sync,
    output logic [LANES*W-1:0]  out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SLOT_W-1:0]   slot,
    output logic                overflow,
    output logic                sync_err
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [W-1:0]        lanes_q [LANES];
    logic [W-1:0]        lanes_d [LANES];
    logic                sync_err_q, sync_err_d;
    logic                frame_done;
    logic [LANES*W-1:0]  frame_data;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        lanes_d    = lanes_q;
        sync_err_d = 1'b0;
        frame_done = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (in_sync) begin
                        lanes_d[0] = in_data;
                        slot_d     = SLOT_W'(1);
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (slot_q == '0) begin
                        // Slot 0 must carry a sync marker; anything else means framing was lost.
                        if (in_sync) begin
                            lanes_d[0] = in_data;
                            slot_d     = SLOT_W'(1);
                        end else begin
                            sync_err_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end else if (in_sync) begin
                        sync_err_d = 1'b1;
                        for (int unsigned k = 1; k < LANES; k++) begin
                            lanes_d[k] = '0;
                        end
                        lanes_d[0] = in_data;
                        slot_d     = SLOT_W'(1);
                    end else begin
                        lanes_d[slot_q] = in_data;
                        slot_d          = slot_q + SLOT_W'(1);
                        frame_done      = (slot_q == LAST_SLOT);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The last lane is taken straight from the incoming sample so the frame loads in the same cycle.
    always_comb begin
        frame_data = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            frame_data[k*W +: W] = (k == LANES - 1) ? in_data : lanes_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            sync_err_q <= 1'b0;
            for (int unsigned k = 0; k < LANES; k++) begin
                lanes_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            sync_err_q <= sync_err_d;
            lanes_q    <= lanes_d;
        end
    end

    tdm_out_buf #(
        .WIDTH (LANES * W)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (frame_done),
        .load_data (frame_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    assign slot     = slot_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed self-checking bench for tdm_demux8: vector table plus hand-written multi-cycle sequences.
module tb_tdm_demux8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sync = 1'b0;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  slot;
    logic        overflow;
    logic        sync_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tdm_demux8 #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot),
        .overflow  (overflow),
        .sync_err  (sync_err)
    );

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic        r;
        logic        ov;
        logic [2:0]  sl;
        logic        se;
        logic        of;
        logic        cd;
        logic [63:0] dat;
    } vec_t;

    function automatic vec_t mk(logic v, logic s, logic [7:0] d, logic r, logic ov,
                                logic [2:0] sl, logic se, logic of, logic cd, logic [63:0] dat);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.r = r; t.ov = ov;
        t.sl = sl; t.se = se; t.of = of; t.cd = cd; t.dat = dat;
        return t;
    endfunction

    task automatic chk1(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(string name, logic ov, logic [2:0] sl, logic se, logic of,
                              logic cd, logic [63:0] dat);
        chk1({name, ".out_valid"}, 64'(out_valid), 64'(ov));
        chk1({name, ".slot"},      64'(slot),      64'(sl));
        chk1({name, ".sync_err"},  64'(sync_err),  64'(se));
        chk1({name, ".overflow"},  64'(overflow),  64'(of));
        if (cd) chk1({name, ".out_data"}, out_data, dat);
    endtask

    // Drive at the falling edge, observe 1ns after the following rising edge.
    task automatic step(string name, logic v, logic s, logic [7:0] d, logic r, logic ov,
                        logic [2:0] sl, logic se, logic of, logic cd, logic [63:0] dat);
        @(negedge clk);
        in_valid  = v;
        in_sync   = s;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
        check_outs(name, ov, sl, se, of, cd, dat);
    endtask

    vec_t tbl [24];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic frame, resync at slot 4, then loss of sync after a completed frame.
        tbl[0]  = mk(1, 1, 8'h10, 1, 0, 1, 0, 0, 0, '0);
        for (int i = 1; i < 7; i++)
            tbl[i] = mk(1, 0, 8'(8'h10 + i), 1, 0, 3'(i + 1), 0, 0, 0, '0);
        tbl[7]  = mk(1, 0, 8'h17, 1, 1, 0, 0, 0, 1, 64'h1716151413121110);
        tbl[8]  = mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, '0);
        tbl[9]  = mk(1, 1, 8'h30, 1, 0, 1, 0, 0, 0, '0);
        tbl[10] = mk(1, 0, 8'h31, 1, 0, 2, 0, 0, 0, '0);
        tbl[11] = mk(1, 0, 8'h32, 1, 0, 3, 0, 0, 0, '0);
        tbl[12] = mk(1, 0, 8'h33, 1, 0, 4, 0, 0, 0, '0);
        tbl[13] = mk(1, 1, 8'h40, 1, 0, 1, 1, 0, 0, '0);
        for (int i = 1; i < 7; i++)
            tbl[13 + i] = mk(1, 0, 8'(8'h40 + i), 1, 0, 3'(i + 1), 0, 0, 0, '0);
        tbl[20] = mk(1, 0, 8'h47, 1, 1, 0, 0, 0, 1, 64'h4746454443424140);
        tbl[21] = mk(1, 0, 8'h55, 1, 0, 0, 1, 0, 0, '0);
        tbl[22] = mk(1, 0, 8'h56, 1, 0, 0, 0, 0, 0, '0);
        tbl[23] = mk(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, '0);

        #1;
        check_outs("reset", 0, 0, 0, 0, 1, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            step($sformatf("tbl%0d", i), tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r,
                 tbl[i].ov, tbl[i].sl, tbl[i].se, tbl[i].of, tbl[i].cd, tbl[i].dat);

        // Same frame with an idle cycle after every sample; slot must hold across gaps.
        for (int k = 0; k < 8; k++) begin
            step($sformatf("gap_s%0d", k), 1, k == 0, 8'(8'h10 + k), 1,
                 k == 7, 3'((k + 1) % 8), 0, 0, k == 7, 64'h1716151413121110);
            step($sformatf("gap_i%0d", k), 0, 0, 8'hEE, 1, 0, 3'((k + 1) % 8), 0, 0, 0, '0);
        end

        // Consumer stalled: frame A held, frame B dropped with one overflow pulse.
        for (int k = 0; k < 8; k++)
            step($sformatf("ovfA%0d", k), 1, k == 0, 8'(8'hA0 + k), 0,
                 k == 7, 3'((k + 1) % 8), 0, 0, k == 7, 64'hA7A6A5A4A3A2A1A0);
        for (int k = 0; k < 8; k++)
            step($sformatf("ovfB%0d", k), 1, k == 0, 8'(8'hB0 + k), 0,
                 1, 3'((k + 1) % 8), 0, k == 7, 1, 64'hA7A6A5A4A3A2A1A0);
        step("ovf_hold", 0, 0, 8'h00, 0, 1, 0, 0, 0, 1, 64'hA7A6A5A4A3A2A1A0);
        step("ovf_pop",  0, 0, 8'h00, 1, 0, 0, 0, 0, 0, '0);

        // Unload and reload in the same cycle keeps out_valid high with the new frame.
        for (int k = 0; k < 8; k++)
            step($sformatf("rlD%0d", k), 1, k == 0, 8'(8'hD0 + k), 0,
                 k == 7, 3'((k + 1) % 8), 0, 0, k == 7, 64'hD7D6D5D4D3D2D1D0);
        for (int k = 0; k < 8; k++)
            step($sformatf("rlE%0d", k), 1, k == 0, 8'(8'hE0 + k), k == 7,
                 1, 3'((k + 1) % 8), 0, 0, 1,
                 (k == 7) ? 64'hE7E6E5E4E3E2E1E0 : 64'hD7D6D5D4D3D2D1D0);
        step("rl_pop", 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, '0);

        // Asynchronous reset mid-frame at slot 5 with a frame held.
        for (int k = 0; k < 8; k++)
            step($sformatf("rstF%0d", k), 1, k == 0, 8'(8'hF0 + k), 0,
                 k == 7, 3'((k + 1) % 8), 0, 0, k == 7, 64'hF7F6F5F4F3F2F1F0);
        for (int k = 0; k < 5; k++)
            step($sformatf("rstG%0d", k), 1, k == 0, 8'(8'h60 + k), 0,
                 1, 3'(k + 1), 0, 0, 0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", 0, 0, 0, 0, 1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 5; k < 8; k++)
            step($sformatf("rst_ign%0d", k), 1, 0, 8'(8'h60 + k), 1, 0, 0, 0, 0, 0, '0);
        for (int k = 0; k < 8; k++)
            step($sformatf("rstH%0d", k), 1, k == 0, 8'(8'h70 + k), 1,
                 k == 7, 3'((k + 1) % 8), 0, 0, k == 7, 64'h7776757473727170);
        step("rst_pop", 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 Parameter: W, default 8, sample width in bits.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_data  input  W  time-multiplexed sample stream.
REQ-005 Port: in_valid  input  1  in_data valid this cycle (no backpressure on input).
REQ-006 Port: in_sync  input  1  marks the current valid sample as slot 0; ignored when in_valid=0.
REQ-007 Port: out_data  output  8*W  demultiplexed frame; lane k at bits [k*W +: W], lane 0 at LSB.
REQ-008 Port: out_valid  output  1  out_data holds a complete frame.
REQ-009 Port: out_ready  input  1  consumer accepts frame when out_valid=1 and out_ready=1.
REQ-010 Port: slot  output  3  index of the next expected slot.
REQ-011 Port: overflow  output  1  one-cycle pulse, completed frame dropped.
REQ-012 Port: sync_err  output  1  one-cycle pulse, framing violation detected.

Function
REQ-013 The block SHALL be the inverse of the team's 8:1 select mux: a sample in slot k SHALL appear on lane k.
REQ-014 States SHALL be IDLE (hunting for sync) and RUN (in frame).
REQ-015 IDLE: valid samples without in_sync SHALL be discarded; valid sample with in_sync SHALL be written to lane 0, slot set to 1, state set to RUN.
REQ-016 RUN, in_valid=1, in_sync=0, slot!=0: sample SHALL be written to lane[slot], slot incremented modulo 8.
REQ-017 RUN, in_valid=1, in_sync=1, slot!=0: sync_err SHALL pulse, partial frame discarded, sample written to lane 0, slot set to 1 (resync, stay RUN).
REQ-018 RUN, slot=0, in_valid=1, in_sync=0: sync_err SHALL pulse, sample discarded, state set to IDLE.
REQ-019 RUN, slot=0, in_valid=1, in_sync=1: treated as start of next frame, per REQ-015 write behaviour.
REQ-020 Acceptance of the slot-7 sample SHALL complete a frame; lanes 0..7 (including slot-7 sample) SHALL be loaded into the output register so out_valid=1 on the next cycle (latency 1 cycle).
REQ-021 Output register SHALL be free if out_valid=0 or out_ready=1 in the completing cycle; simultaneous unload and reload SHALL keep out_valid=1 with the new frame.
REQ-022 If the output register is not free at frame completion, the frame SHALL be dropped, overflow pulses next cycle, held frame unchanged, slot wraps to 0 in RUN.
REQ-023 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 out_valid SHALL clear the cycle after acceptance unless reloaded per REQ-021.
REQ-025 in_valid=0 cycles SHALL not change state, slot, or lanes (gaps allowed anywhere in a frame).

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, slot 0, out_valid 0, out_data 0, overflow 0, sync_err 0, lane registers 0.
REQ-027 Reset mid-frame SHALL discard the partial frame and any held output frame; first frame after release requires in_sync.

Structure
REQ-028 Shared package SHALL hold: lane count constant (8), slot width constant (3), state enum {IDLE, RUN}.
REQ-029 One sub-module SHALL be used: tdm_out_buf, the valid/ready output holding register (8*W wide) with free/load/drop logic.
REQ-030 Lane write decode SHALL be a slot-indexed register write; no combinational path from in_* to out_*.

Verification
REQ-031 Reset, then in_sync on sample 0x10, samples 0x11..0x17, out_ready=1 -> out_valid one cycle after 0x17, out_data=0x1716151413121110.
REQ-032 Same frame with idle gaps (in_valid=0) between every sample -> identical out_data, slot holds during gaps.
REQ-033 out_ready=0, two complete frames A then B -> out_valid stays 1 with A, overflow pulses once after B's slot 7; out_ready=1 then returns A.
REQ-034 in_sync asserted at slot 4 -> sync_err pulse, slot=1, next 7 samples complete a frame with the resync sample in lane 0.
REQ-035 Frame complete, next valid sample without in_sync -> sync_err pulse, state IDLE, samples ignored until in_sync.
REQ-036 rst_n=0 asserted asynchronously mid-frame at slot 5 and with out_valid=1 -> out_valid=0, slot=0 immediately; no frame emitted until a new full synced frame.
